mem_axil_master: RTL and testbench
==================================

Name: mem_axil_master

Overview:
- AXI4-Lite master downstream of mem_stage: takes the load/store request (address, word data, byte strobes) and runs one AXI4-Lite transaction per request.
- Holds the CPU pipeline with `stall` until the transaction completes, then returns the raw 32-bit read word; mem_stage does byte/halfword extraction and sign/zero extension.

Parameters:
ADDR_WIDTH, 32, width of req_addr/m_awaddr/m_araddr
BUSY_ON_IDLE_REQ, 1, 1 = stall asserted combinationally in the IDLE cycle a request appears (required for in-order pipeline)

Ports:
clk  input  1  system clock
rst  input  1  reset
req_read  input  1  load request from mem_stage (held stable while stall=1)
req_write  input  1  store request from mem_stage (held stable while stall=1)
req_addr  input  ADDR_WIDTH  byte address (calculated result)
req_wdata  input  32  store data, byte lanes pre-aligned
req_wstrb  input  4  byte strobes from store_type/offset
stall  output  1  freeze pipeline stages up to and including MEM
rsp_rdata  output  32  captured R-channel data, held until next read completes
rsp_error  output  1  one-cycle pulse in DONE if BRESP/RRESP != OKAY
m_awaddr  output  ADDR_WIDTH  write address
m_awvalid  output  1  write address valid
m_awready  input  1  write address ready
m_wdata  output  32  write data
m_wstrb  output  4  write strobes
m_wvalid  output  1  write data valid
m_wready  input  1  write data ready
m_bresp  input  2  write response
m_bvalid  input  1  write response valid
m_bready  output  1  write response ready
m_araddr  output  ADDR_WIDTH  read address
m_arvalid  output  1  read address valid
m_arready  input  1  read address ready
m_rdata  input  32  read data
m_rresp  input  2  read response
m_rvalid  input  1  read data valid
m_rready  output  1  read data ready

Behaviour:
- Clock `clk`; reset `rst` is synchronous and active-high. Reset: state=IDLE; all valid/ready outputs 0; rsp_rdata=0; rsp_error=0; aw_done=w_done=0. Reset mid-transaction drops all valids at that edge; the slave shares the same rst.
- AxPROT is not implemented; the interconnect ties it to 3'b000.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- stall=1 in IDLE when (req_read|req_write); stall=1 in WR, WR_RESP, RD_ADDR, RD_DATA; stall=0 in DONE.
- IDLE: register addr/wdata/wstrb on a request. req_write → WR (write wins if both are set). req_read only → RD_ADDR.
- WR: m_awvalid=!aw_done and m_wvalid=!w_done, each dropping after its own handshake. AW and W may complete in either order or the same cycle. → WR_RESP once both are done, counting a handshake in the current cycle.
- WR_RESP: m_bready=1; on bvalid → DONE, latch error=(bresp!=2'b00).
- RD_ADDR: m_arvalid=1; on arready → RD_DATA.
- RD_DATA: m_rready=1; on rvalid capture m_rdata into rsp_rdata, latch error, → DONE.
- DONE: rsp_error=latched error for exactly this cycle. Unconditionally → IDLE, even if the request inputs are still high (that instruction advances at this edge). Then clear aw_done/w_done.
- Minimum latency with a zero-wait slave: read 4 cycles of stall=1 then DONE; write 4 cycles of stall=1 then DONE.
- Valid outputs are registered and never depend combinationally on ready inputs.
- Once asserted, a valid stays high until its handshake.

Optional Feature:
AXIL_POSTED_WRITE_EN
- Defined: a write goes WR → DONE as soon as AW and W are both accepted. A b_pending flag holds bready=1 until B arrives.
- Any new request seen while b_pending is set stalls in IDLE until B is received.
- A B error is reported as a rsp_error pulse in the cycle B arrives.
- Undefined: non-posted behaviour as above.

Decomposition:
- Shared package/defines.vh: state encodings, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- No sub-module; single FSM file.

Test Plan:
- Read, arready/rvalid immediate, rdata=32'hCAFEF00D → stall high 4 cycles, DONE with rsp_rdata=32'hCAFEF00D, rsp_error=0.
- Write, wstrb=4'b0100, awready at cycle 1, wready delayed to cycle 4 → awvalid drops after cycle 1, wvalid held until cycle 4, single B, stall low only in DONE.
- req_read=req_write=1 → only AW/W issued, no arvalid ever.
- rresp=2'b10 → rsp_error=1 for exactly one cycle; rdata still captured.
- rst asserted while in RD_DATA → next cycle all valids/readies 0, state IDLE, stall follows request inputs; back-to-back loads complete without a duplicate AR.

Source files
------------

// File: rtl/mem_axil_master_pkg.sv
// Shared FSM state encoding and AXI response codes for the mem_stage AXI4-Lite master.
package mem_axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // EXOKAY has no meaning on AXI4-Lite, so anything but OKAY is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:                                     return 1'b0;
            AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_axil_master.sv
// One AXI4-Lite transaction per mem_stage load/store; stalls the pipeline until done.
// Optional build macro AXIL_POSTED_WRITE_EN: writes finish at AW/W acceptance, B tracked by b_pending.
module mem_axil_master
    import mem_axil_master_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter bit BUSY_ON_IDLE_REQ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  stall,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  b_wait;
    logic                  req_any;

`ifdef AXIL_POSTED_WRITE_EN
    logic                  b_pending_q, b_pending_d;
    assign b_wait = b_pending_q;
`else
    assign b_wait = 1'b0;
`endif

    assign req_any = req_read | req_write;

    // Valids are driven from flops that are only set while already in the issuing
    // state, so they never follow a ready input combinationally.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q | (awvalid_q & m_awready);
        w_done_d  = w_done_q | (wvalid_q & m_wready);
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
`ifdef AXIL_POSTED_WRITE_EN
        b_pending_d = b_pending_q & ~m_bvalid;
`endif
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (!b_wait && req_any) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = req_write ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                awvalid_d = ~aw_done_d;
                wvalid_d  = ~w_done_d;
                if (aw_done_d && w_done_d) begin
`ifdef AXIL_POSTED_WRITE_EN
                    state_d     = ST_DONE;
                    b_pending_d = 1'b1;
`else
                    state_d = ST_WR_RESP;
`endif
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    err_d   = resp_is_err(m_bresp);
                    state_d = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                arvalid_d = ~(arvalid_q & m_arready);
                if (arvalid_q && m_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    err_d   = resp_is_err(m_rresp);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef AXIL_POSTED_WRITE_EN
    always_ff @(posedge clk) begin
        if (rst) b_pending_q <= 1'b0;
        else     b_pending_q <= b_pending_d;
    end
`endif

    always_comb begin
        case (state_q)
            ST_IDLE: stall = req_any & (BUSY_ON_IDLE_REQ | b_wait);
            ST_DONE: stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    assign rsp_error = (state_q == ST_DONE && err_q)
                     | (b_wait & m_bvalid & resp_is_err(m_bresp));
    assign rsp_rdata = rdata_q;
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_arvalid = arvalid_q;
    assign m_bready  = (state_q == ST_WR_RESP) | b_wait;
    assign m_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_mem_axil_master.sv
// Directed self-checking bench for mem_axil_master (non-posted build) with a small registered AXI-Lite slave.
module tb_mem_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    // slave configuration (written by the stimulus) and observation counters
    logic [31:0] rd_base;
    logic [1:0]  rresp_cfg, bresp_cfg;
    int          r_lat_cfg;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, arv_cycles = 0;
    logic        aw_got, w_got, r_busy;
    int          r_cnt;
    logic [31:0] rdata_hold;

    int n_compared = 0;
    int n_mismatched = 0;

    mem_axil_master #(.ADDR_WIDTH(32), .BUSY_ON_IDLE_REQ(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .stall(stall), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_arvalid) arv_cycles <= arv_cycles + 1;
        if (m_arvalid && m_arready) ar_cnt <= ar_cnt + 1;
        if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
        if (m_wvalid && m_wready) w_cnt <= w_cnt + 1;
        if (m_bvalid && m_bready) b_cnt <= b_cnt + 1;
        if (rst) begin
            m_rvalid <= 1'b0; m_bvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0; m_bresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; r_busy <= 1'b0; r_cnt <= 0; rdata_hold <= '0;
        end else begin
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                if (r_lat_cfg == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= rd_base + m_araddr;
                    m_rresp  <= rresp_cfg;
                end else begin
                    r_busy     <= 1'b1;
                    r_cnt      <= r_lat_cfg - 1;
                    rdata_hold <= rd_base + m_araddr;
                end
            end
            if (r_busy) begin
                if (r_cnt == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= rdata_hold;
                    m_rresp  <= rresp_cfg;
                    r_busy   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if ((aw_got | (m_awvalid & m_awready)) && (w_got | (m_wvalid & m_wready))) begin
                m_bvalid <= 1'b1;
                m_bresp  <= bresp_cfg;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                aw_got <= aw_got | (m_awvalid & m_awready);
                w_got  <= w_got | (m_wvalid & m_wready);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a request is driven in an IDLE cycle; returns positioned in DONE.
    task automatic run_txn(input int budget, output int n_stall, output int n_err);
        n_stall = 0;
        n_err   = 0;
        #1;
        while (stall && n_stall < budget) begin
            if (rsp_error) n_err++;
            n_stall++;
            @(negedge clk); #1;
        end
        if (rsp_error) n_err++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          ns, ne, ar0, aw0, w0, b0, arv0;
        logic [6:0]  exp_aw, exp_w, exp_stall, exp_bready;

        rst = 1'b1;
        req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b1;
        rd_base = 32'hCAFE_F00D; rresp_cfg = 2'b00; bresp_cfg = 2'b00; r_lat_cfg = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        // reset state
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, 1'b0}, 32'd0);
        check_eq("rst_readies", {30'd0, m_bready, m_rready}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_error", 32'(rsp_error), 32'd0);
        rst = 1'b0;

        // zero-wait read
        @(negedge clk);
        ar0 = ar_cnt;
        req_read = 1'b1; req_addr = 32'h0;
        run_txn(20, ns, ne);
        check_eq("rd_stall_cycles", 32'(ns), 32'd4);
        check_eq("rd_rdata", rsp_rdata, 32'hCAFE_F00D);
        check_eq("rd_err_cycles", 32'(ne), 32'd0);
        req_read = 1'b0;
        @(negedge clk); #1;
        check_eq("rd_idle_stall", 32'(stall), 32'd0);
        check_eq("rd_ar_count", 32'(ar_cnt - ar0), 32'd1);

        // write: AW accepted immediately, W ready only from cycle 4
        exp_aw     = 7'b0000100;
        exp_w      = 7'b0011100;
        exp_bready = 7'b0100000;
        exp_stall  = 7'b0111111;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        m_awready = 1'b1; m_wready = 1'b0;
        req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'h00AB_0000; req_wstrb = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) m_wready = 1'b1;
            #1;
            check_eq($sformatf("wr_stall_c%0d", c), 32'(stall), 32'(exp_stall[c]));
            check_eq($sformatf("wr_awvalid_c%0d", c), 32'(m_awvalid), 32'(exp_aw[c]));
            check_eq($sformatf("wr_wvalid_c%0d", c), 32'(m_wvalid), 32'(exp_w[c]));
            check_eq($sformatf("wr_bready_c%0d", c), 32'(m_bready), 32'(exp_bready[c]));
            if (c == 2) begin
                check_eq("wr_awaddr", m_awaddr, 32'h44);
                check_eq("wr_wdata", m_wdata, 32'h00AB_0000);
                check_eq("wr_wstrb", 32'(m_wstrb), 32'h4);
            end
        end
        check_eq("wr_done_error", 32'(rsp_error), 32'd0);
        req_write = 1'b0; m_wready = 1'b0;
        @(negedge clk); #1;
        check_eq("wr_aw_count", 32'(aw_cnt - aw0), 32'd1);
        check_eq("wr_w_count", 32'(w_cnt - w0), 32'd1);
        check_eq("wr_b_count", 32'(b_cnt - b0), 32'd1);
        check_eq("wr_rdata_held", rsp_rdata, 32'hCAFE_F00D);

        // read and write together: write wins, no AR ever
        arv0 = arv_cycles; aw0 = aw_cnt;
        m_awready = 1'b1; m_wready = 1'b1;
        req_read = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wstrb = 4'b1111;
        run_txn(20, ns, ne);
        check_eq("rw_stall_cycles", 32'(ns), 32'd4);
        req_read = 1'b0; req_write = 1'b0;
        @(negedge clk); #1;
        check_eq("rw_no_arvalid", 32'(arv_cycles - arv0), 32'd0);
        check_eq("rw_aw_count", 32'(aw_cnt - aw0), 32'd1);

        // read with SLVERR
        rd_base = 32'h0BAD_0000; rresp_cfg = 2'b10;
        req_read = 1'b1; req_addr = 32'h8;
        run_txn(20, ns, ne);
        check_eq("rerr_stall_cycles", 32'(ns), 32'd4);
        check_eq("rerr_done_error", 32'(rsp_error), 32'd1);
        check_eq("rerr_rdata", rsp_rdata, 32'h0BAD_0008);
        req_read = 1'b0;
        @(negedge clk); #1;
        check_eq("rerr_pulse_end", 32'(rsp_error), 32'd0);
        check_eq("rerr_err_cycles", 32'(ne), 32'd1);
        rresp_cfg = 2'b00;

        // reset while waiting in RD_DATA
        r_lat_cfg = 5;
        req_read = 1'b1; req_addr = 32'h30;
        ns = 0;
        #1;
        while (!m_rready && ns < 20) begin
            @(negedge clk); #1;
            ns++;
        end
        check_eq("mid_reached_rd_data", 32'(m_rready), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("mid_valids", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
        check_eq("mid_readies", {30'd0, m_bready, m_rready}, 32'd0);
        check_eq("mid_stall_req_hi", 32'(stall), 32'd1);
        rst = 1'b0; req_read = 1'b0;
        #1;
        check_eq("mid_stall_req_lo", 32'(stall), 32'd0);
        r_lat_cfg = 0;

        // back-to-back loads, second request presented at the DONE edge
        @(negedge clk);
        ar0 = ar_cnt;
        rd_base = 32'h1000_0000;
        req_read = 1'b1; req_addr = 32'h10;
        run_txn(20, ns, ne);
        check_eq("b2b_first_stall", 32'(ns), 32'd4);
        check_eq("b2b_first_rdata", rsp_rdata, 32'h1000_0010);
        req_addr = 32'h20;
        @(negedge clk);
        run_txn(20, ns, ne);
        check_eq("b2b_second_stall", 32'(ns), 32'd4);
        check_eq("b2b_second_rdata", rsp_rdata, 32'h1000_0020);
        req_read = 1'b0;
        @(negedge clk); #1;
        check_eq("b2b_ar_count", 32'(ar_cnt - ar0), 32'd2);
        check_eq("b2b_idle_stall", 32'(stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
